// File: rtl/alu_logic_pipe.sv
// Two-stage pipelined logic/shift unit: 16 truth-table logic ops plus four
// single-bit shifts/rotates through carry. Full valid/ready backpressure.
module alu_logic_pipe #(
    parameter int data_wl = 16,
    parameter int op_wl   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [data_wl-1:0] a_in,
    input  logic [data_wl-1:0] b_in,
    input  logic [op_wl-1:0]   op_in,
    input  logic               z_flag_in,
    input  logic               s_flag_in,
    input  logic               c_flag_in,
    input  logic               ovr_flag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [data_wl-1:0] c_out,
    output logic               z_flag_out,
    output logic               s_flag_out,
    output logic               c_flag_out,
    output logic               ovr_flag_out,
    output logic               op_active
);

    // Packed compute result: {act, ovr, c, s, z, result}
    localparam int RES_W = data_wl + 5;

    logic               vld_p1;
    logic               vld_p2;
    logic               adv_p1;
    logic               adv_p2;
    logic [data_wl-1:0] a_p1;
    logic [data_wl-1:0] b_p1;
    logic [op_wl-1:0]   op_p1;
    logic               c_p1;
    logic               ovr_p1;
    logic [RES_W-1:0]   calc_p1;
    logic [data_wl-1:0] res_p2;
    logic               z_p2;
    logic               s_p2;
    logic               c_p2;
    logic               ovr_p2;
    logic               act_p2;
    logic               flags_unused;

    // Low opcode nibble is the truth table indexed by {b, a} per bit.
    function automatic logic [data_wl-1:0] truth_table(
        input logic [3:0]         tt,
        input logic [data_wl-1:0] a,
        input logic [data_wl-1:0] b
    );
        logic [data_wl-1:0] r;
        r = '0;
        for (int i = 0; i < data_wl; i++) begin
            r[i] = tt[{b[i], a[i]}];
        end
        return r;
    endfunction

    function automatic logic [RES_W-1:0] compute(
        input logic [data_wl-1:0] a,
        input logic [data_wl-1:0] b,
        input logic [op_wl-1:0]   op,
        input logic               cin,
        input logic               ovr
    );
        logic [data_wl-1:0] r;
        logic               c;
        logic               act;
        r   = '0;
        c   = cin;
        act = 1'b0;
        if (op[op_wl-1:4] == (op_wl-4)'(4)) begin
            r   = truth_table(op[3:0], a, b);
            act = 1'b1;
        end else if (op[op_wl-1:2] == (op_wl-2)'(20)) begin
            act = 1'b1;
            case (op[1:0])
                2'd0: begin r = {a[data_wl-2:0], 1'b0}; c = a[data_wl-1]; end
                2'd1: begin r = {1'b0, a[data_wl-1:1]}; c = a[0];         end
                2'd2: begin r = {a[data_wl-2:0], cin};  c = a[data_wl-1]; end
                2'd3: begin r = {cin, a[data_wl-1:1]};  c = a[0];         end
            endcase
        end
        // Unrecognised ops leave r at zero, so z=1 and s=0 fall out naturally.
        return {act, ovr, c, r[data_wl-1], (r == '0), r};
    endfunction

    assign flags_unused = z_flag_in ^ s_flag_in;

    assign adv_p2   = !vld_p2 || out_ready;
    assign adv_p1   = !vld_p1 || adv_p2;
    assign in_ready = !reset && adv_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (adv_p1) vld_p1 <= in_valid;
            if (adv_p2) vld_p2 <= vld_p1;
        end
    end

    // Stage 1: operand capture
    always_ff @(posedge clk) begin
        if (adv_p1 && in_valid) begin
            a_p1   <= a_in;
            b_p1   <= b_in;
            op_p1  <= op_in;
            c_p1   <= c_flag_in;
            ovr_p1 <= ovr_flag_in;
        end
    end

    assign calc_p1 = compute(a_p1, b_p1, op_p1, c_p1, ovr_p1);

    // Stage 2: result and flags; held bit-stable while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            res_p2 <= '0;
            z_p2   <= 1'b0;
            s_p2   <= 1'b0;
            c_p2   <= 1'b0;
            ovr_p2 <= 1'b0;
            act_p2 <= 1'b0;
        end else if (adv_p2 && vld_p1) begin
            {act_p2, ovr_p2, c_p2, s_p2, z_p2, res_p2} <= calc_p1;
        end
    end

    assign out_valid    = vld_p2;
    assign c_out        = res_p2;
    assign z_flag_out   = z_p2;
    assign s_flag_out   = s_p2;
    assign c_flag_out   = c_p2;
    assign ovr_flag_out = ovr_p2;
    assign op_active    = act_p2;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Scoreboard bench for alu_logic_pipe: a 16-bit and a 5-bit instance checked
// against a behavioural model of the opcode table.
module tb_alu_logic_pipe;

    localparam int W  = 16;
    localparam int W5 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic [7:0]    op_in = '0;
    logic          z_flag_in = 1'b0, s_flag_in = 1'b0, c_flag_in = 1'b0, ovr_flag_in = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  c_out;
    logic          z_flag_out, s_flag_out, c_flag_out, ovr_flag_out, op_active;

    logic          n5_in_valid = 1'b0;
    logic          n5_in_ready;
    logic [W5-1:0] n5_a_in = '0;
    logic [W5-1:0] n5_b_in = '0;
    logic [7:0]    n5_op_in = '0;
    logic          n5_c_flag_in = 1'b0, n5_ovr_flag_in = 1'b0;
    logic          n5_out_valid;
    logic          n5_out_ready = 1'b1;
    logic [W5-1:0] n5_c_out;
    logic          n5_z, n5_s, n5_c, n5_ovr, n5_act;

    alu_logic_pipe #(.data_wl(W), .op_wl(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .z_flag_in(z_flag_in), .s_flag_in(s_flag_in), .c_flag_in(c_flag_in), .ovr_flag_in(ovr_flag_in),
        .out_valid(out_valid), .out_ready(out_ready), .c_out(c_out),
        .z_flag_out(z_flag_out), .s_flag_out(s_flag_out), .c_flag_out(c_flag_out),
        .ovr_flag_out(ovr_flag_out), .op_active(op_active)
    );

    alu_logic_pipe #(.data_wl(W5), .op_wl(8)) dut5 (
        .clk(clk), .reset(reset), .in_valid(n5_in_valid), .in_ready(n5_in_ready),
        .a_in(n5_a_in), .b_in(n5_b_in), .op_in(n5_op_in),
        .z_flag_in(1'b0), .s_flag_in(1'b1), .c_flag_in(n5_c_flag_in), .ovr_flag_in(n5_ovr_flag_in),
        .out_valid(n5_out_valid), .out_ready(n5_out_ready), .c_out(n5_c_out),
        .z_flag_out(n5_z), .s_flag_out(n5_s), .c_flag_out(n5_c),
        .ovr_flag_out(n5_ovr), .op_active(n5_act)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        s;
        logic        c;
        logic        ovr;
        logic        act;
    } exp_t;

    exp_t q16[$];
    exp_t q5[$];
    exp_t e16, e5;
    int   checks = 0;
    int   failures = 0;
    int   ready_mode = 0;

    // Reference: the named function of each opcode, computed on 32-bit values then masked
    function automatic exp_t model(input int w, input logic [31:0] a_i, input logic [31:0] b_i,
                                   input logic [7:0] op, input logic cin, input logic ovr);
        exp_t        e;
        logic [31:0] mask, a, b, r;
        mask  = (32'h1 << w) - 32'h1;
        a     = a_i & mask;
        b     = b_i & mask;
        r     = 32'h0;
        e.act = 1'b1;
        e.c   = cin;
        e.ovr = ovr;
        case (op)
            8'h40: r = 32'h0;
            8'h41: r = ~(a | b);
            8'h42: r = a & ~b;
            8'h43: r = ~b;
            8'h44: r = ~a & b;
            8'h45: r = ~a;
            8'h46: r = a ^ b;
            8'h47: r = ~(a & b);
            8'h48: r = a & b;
            8'h49: r = ~(a ^ b);
            8'h4A: r = a;
            8'h4B: r = a | ~b;
            8'h4C: r = b;
            8'h4D: r = ~a | b;
            8'h4E: r = a | b;
            8'h4F: r = 32'hFFFF_FFFF;
            8'h50: begin r = a << 1;                               e.c = a[w-1]; end
            8'h51: begin r = a >> 1;                               e.c = a[0];   end
            8'h52: begin r = (a << 1) | {31'b0, cin};              e.c = a[w-1]; end
            8'h53: begin r = (a >> 1) | ({31'b0, cin} << (w - 1)); e.c = a[0];   end
            default: e.act = 1'b0;
        endcase
        r     = r & mask;
        e.res = r;
        e.z   = (r == 32'h0);
        e.s   = r[w-1];
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q16.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w16_extra_beat actual=%0h required=none", c_out);
            end else begin
                e16 = q16.pop_front();
                chk("w16_result", 32'(c_out), e16.res);
                chk("w16_z", 32'(z_flag_out), 32'(e16.z));
                chk("w16_s", 32'(s_flag_out), 32'(e16.s));
                chk("w16_c", 32'(c_flag_out), 32'(e16.c));
                chk("w16_ovr", 32'(ovr_flag_out), 32'(e16.ovr));
                chk("w16_op_active", 32'(op_active), 32'(e16.act));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && n5_out_valid && n5_out_ready) begin
            if (q5.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w5_extra_beat actual=%0h required=none", n5_c_out);
            end else begin
                e5 = q5.pop_front();
                chk("w5_result", 32'(n5_c_out), e5.res);
                chk("w5_z", 32'(n5_z), 32'(e5.z));
                chk("w5_s", 32'(n5_s), 32'(e5.s));
                chk("w5_c", 32'(n5_c), 32'(e5.c));
                chk("w5_ovr", 32'(n5_ovr), 32'(e5.ovr));
                chk("w5_op_active", 32'(n5_act), 32'(e5.act));
            end
        end
    end

    task automatic set_ready(input int m);
        ready_mode = m;
        @(posedge clk);
        #3;
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op,
                          input logic cin, input logic ovr);
        int n;
        in_valid    = 1'b1;
        a_in        = a;
        b_in        = b;
        op_in       = op;
        c_flag_in   = cin;
        ovr_flag_in = ovr;
        z_flag_in   = 1'($urandom);
        s_flag_in   = 1'($urandom);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL w16_accept_timeout actual=in_ready_low required=accept");
        end else begin
            q16.push_back(model(W, 32'(a), 32'(b), op, cin, ovr));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send5(input logic [4:0] a, input logic [4:0] b, input logic [7:0] op,
                         input logic cin, input logic ovr);
        int n;
        n5_in_valid    = 1'b1;
        n5_a_in        = a;
        n5_b_in        = b;
        n5_op_in       = op;
        n5_c_flag_in   = cin;
        n5_ovr_flag_in = ovr;
        n = 0;
        @(negedge clk);
        while (!n5_in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!n5_in_ready) begin
            checks++;
            failures++;
            $display("FAIL w5_accept_timeout actual=in_ready_low required=accept");
        end else begin
            q5.push_back(model(W5, 32'(a), 32'(b), op, cin, ovr));
        end
        @(posedge clk);
        #1;
        n5_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        set_ready(1);
        n = 0;
        while ((q16.size() != 0 || q5.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(q16.size() + q5.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_op();
        int k;
        k = $urandom_range(0, 9);
        if (k < 6) return 8'h40 + 8'($urandom_range(0, 15));
        if (k < 8) return 8'h50 + 8'($urandom_range(0, 3));
        return 8'($urandom);
    endfunction

    logic [21:0] snap;
    int          lat;

    initial begin
        // Reset state
        @(negedge clk);
        chk("in_ready_in_reset", 32'(in_ready), 32'h0);
        chk("out_valid_in_reset", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'h1);
        chk("c_out_after_reset", 32'(c_out), 32'h0);
        chk("flags_after_reset", 32'({z_flag_out, s_flag_out, c_flag_out, ovr_flag_out, op_active}), 32'h0);
        @(posedge clk);
        #1;

        // Logic sweep, shifts, unknown op
        set_ready(1);
        for (int i = 0; i < 16; i++)
            send16(16'hF0F0, 16'hCCCC, 8'h40 + 8'(i), 1'($urandom), 1'($urandom));
        send16(16'h8001, 16'h1234, 8'h50, 1'b0, 1'b0);
        send16(16'h8001, 16'h1234, 8'h51, 1'b0, 1'b1);
        send16(16'h8001, 16'h1234, 8'h52, 1'b1, 1'b0);
        send16(16'h8001, 16'h1234, 8'h53, 1'b1, 1'b1);
        send16(16'hFFFF, 16'h5A5A, 8'h20, 1'b1, 1'b1);
        drain();

        // Backpressure: two accepts fill the pipe, third waits
        set_ready(0);
        send16(16'h1357, 16'h00FF, 8'h4E, 1'b0, 1'b1);
        send16(16'hABCD, 16'h0F0F, 8'h52, 1'b1, 1'b0);
        in_valid    = 1'b1;
        a_in        = 16'h0F00;
        b_in        = 16'h0FF0;
        op_in       = 8'h46;
        c_flag_in   = 1'b1;
        ovr_flag_in = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_full", 32'(in_ready), 32'h0);
        chk("bp_out_valid", 32'(out_valid), 32'h1);
        snap = {out_valid, c_out, z_flag_out, s_flag_out, c_flag_out, ovr_flag_out, op_active};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_hold", 32'(in_ready), 32'h0);
            chk("bp_outputs_stable",
                32'({out_valid, c_out, z_flag_out, s_flag_out, c_flag_out, ovr_flag_out, op_active}),
                32'(snap));
        end
        ready_mode = 1;
        @(posedge clk);
        #3;
        @(negedge clk);
        chk("bp_in_ready_release", 32'(in_ready), 32'h1);
        if (in_ready) q16.push_back(model(W, 32'h0F00, 32'h0FF0, 8'h46, 1'b1, 1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Randomised stream with random backpressure and input gaps
        set_ready(2);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send16(16'($urandom), 16'($urandom), rand_op(), 1'($urandom), 1'($urandom));
        end
        drain();

        // Reset with two beats in flight
        set_ready(0);
        send16(16'h1111, 16'h2222, 8'h48, 1'b1, 1'b1);
        send16(16'h3333, 16'h4444, 8'h4F, 1'b1, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready_during_reset", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q16.delete();
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(out_valid), 32'h0);
        chk("rst_mid_c_out", 32'(c_out), 32'h0);
        chk("rst_mid_flags", 32'({z_flag_out, s_flag_out, c_flag_out, ovr_flag_out, op_active}), 32'h0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'h1);
        set_ready(1);
        send16(16'h00F0, 16'h0FF0, 8'h42, 1'b0, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        chk("latency_after_reset", 32'(lat), 32'd2);
        drain();

        // Narrow instance
        send5(5'h0A, 5'h03, 8'h4F, 1'b0, 1'b1);
        send5(5'h10, 5'h1F, 8'h50, 1'b0, 1'b0);
        send5(5'h11, 5'h00, 8'h53, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++)
            send5(5'($urandom), 5'($urandom), rand_op(), 1'($urandom), 1'($urandom));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
